// File: rtl/dual_mem_ctrl.sv
// Request controller in front of a 256x16 dual-port memory with registered read.
// Round-robin arbitration between a write client and a read client; reads return a one-cycle response pulse.
`timescale 1ns/1ps
module dual_mem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_rsp_valid,
    output logic [DATA_W-1:0] rd_rsp_data,
    output logic              busy,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_wr_address,
    output logic [ADDR_W-1:0] mem_rd_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_rd_q, last_rd_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic grant_wr;
    logic grant_rd;

    // Under contention the port that did not win last time is served.
    assign grant_wr = wr_req_valid && (!rd_req_valid || last_rd_q);
    assign grant_rd = rd_req_valid && (!wr_req_valid || !last_rd_q);

    assign wr_req_ready   = (state_q == IDLE) && grant_wr;
    assign rd_req_ready   = (state_q == IDLE) && grant_rd;
    assign busy           = (state_q != IDLE);
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;
    assign mem_wr_address = wr_addr_q;
    assign mem_rd_address = rd_addr_q;
    assign mem_data_in    = wr_data_q;
    assign rd_rsp_valid   = rsp_valid_q;
    assign rd_rsp_data    = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        last_rd_d   = last_rd_q;
        mem_write_d = mem_write_q;
        mem_read_d  = mem_read_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_data_d   = wr_data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    wr_addr_d   = wr_req_addr;
                    wr_data_d   = wr_req_data;
                    mem_write_d = 1'b1;
                    last_rd_d   = 1'b0;
                    state_d     = WR;
                end else if (grant_rd) begin
                    rd_addr_d  = rd_req_addr;
                    mem_read_d = 1'b1;
                    last_rd_d  = 1'b1;
                    state_d    = RD;
                end
            end
            WR: begin
                mem_write_d = 1'b0;
                state_d     = IDLE;
            end
            RD: begin
                mem_read_d = 1'b0;
                state_d    = CAP;
            end
            CAP: begin
                // Memory output became valid this cycle, one edge after the read strobe.
                rsp_data_d  = mem_data_out;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_rd_q   <= 1'b1;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_rd_q   <= last_rd_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_data_q   <= wr_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_dual_mem_ctrl.sv
// Bench for dual_mem_ctrl: behavioural memory plus a cycle-timed transaction model of the controller.
`timescale 1ns/1ps
module tb_dual_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req_valid, wr_req_ready;
    logic [7:0]  wr_req_addr;
    logic [15:0] wr_req_data;
    logic        rd_req_valid, rd_req_ready;
    logic [7:0]  rd_req_addr;
    logic        rd_rsp_valid;
    logic [15:0] rd_rsp_data;
    logic        busy, mem_write, mem_read;
    logic [7:0]  mem_wr_address, mem_rd_address;
    logic [15:0] mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    dual_mem_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .busy(busy), .mem_write(mem_write), .mem_read(mem_read),
        .mem_wr_address(mem_wr_address), .mem_rd_address(mem_rd_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Memory with registered read that zeroes its output on a read/write collision.
    logic [15:0] tb_mem [256];
    logic [15:0] mem_dout_q;
    logic        preload;

    function automatic logic [15:0] pat(input int i);
        return 16'((i * 257) ^ 16'h5A3C);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= pat(i);
        end else if (mem_write && mem_read) begin
            mem_dout_q <= '0;
        end else begin
            if (mem_write) tb_mem[mem_wr_address] <= mem_data_in;
            if (mem_read)  mem_dout_q <= tb_mem[mem_rd_address];
        end
    end
    assign mem_data_out = mem_dout_q;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          free_cyc, wr_cyc, rd_cyc, last_rd_acc;
    bit          last_rd;
    logic [7:0]  e_wa, e_ra;
    logic [15:0] e_din, e_rsp;
    logic [15:0] ref_mem [256];
    logic [23:0] wq [$];
    logic [7:0]  rq [$];
    int          rsp_cyc_q [$];
    logic [15:0] rsp_dat_q [$];
    int          rsp_log [$];
    string       grants;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_str(input string name, input string got, input string exp);
        checks++;
        assert (got == exp) else begin
            failures++;
            $error("FAIL %s: got %s expected %s", name, got, exp);
        end
    endtask

    task automatic model_reset();
        free_cyc = 0; wr_cyc = -10; rd_cyc = -10; last_rd = 1'b1;
        e_wa = '0; e_ra = '0; e_din = '0; e_rsp = '0;
        rsp_cyc_q.delete(); rsp_dat_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_mwr"},    32'(mem_write), 0);
        chk({tag, "_mrd"},    32'(mem_read), 0);
        chk({tag, "_wa"},     32'(mem_wr_address), 0);
        chk({tag, "_ra"},     32'(mem_rd_address), 0);
        chk({tag, "_din"},    32'(mem_data_in), 0);
        chk({tag, "_rspv"},   32'(rd_rsp_valid), 0);
        chk({tag, "_rspd"},   32'(rd_rsp_data), 0);
    endtask

    task automatic drive();
        wr_req_valid = (wq.size() != 0);
        wr_req_addr  = (wq.size() != 0) ? wq[0][23:16] : 8'h00;
        wr_req_data  = (wq.size() != 0) ? wq[0][15:0]  : 16'h0000;
        rd_req_valid = (rq.size() != 0);
        rd_req_addr  = (rq.size() != 0) ? rq[0] : 8'h00;
    endtask

    // One clock of checking: outputs against the model, then the model's own grant decision.
    task automatic run_cycle();
        bit idle, gw, gr;
        drive();
        #1;
        chk("busy",      32'(busy),      32'(cyc < free_cyc));
        chk("mem_write", 32'(mem_write), 32'(cyc == wr_cyc));
        chk("mem_read",  32'(mem_read),  32'(cyc == rd_cyc));
        chk("collision", 32'(mem_write && mem_read), 0);
        chk("wr_addr",   32'(mem_wr_address), 32'(e_wa));
        chk("wr_data",   32'(mem_data_in),    32'(e_din));
        chk("rd_addr",   32'(mem_rd_address), 32'(e_ra));
        if (rsp_cyc_q.size() != 0 && rsp_cyc_q[0] == cyc) begin
            chk("rsp_valid", 32'(rd_rsp_valid), 1);
            e_rsp = rsp_dat_q[0];
            void'(rsp_cyc_q.pop_front());
            void'(rsp_dat_q.pop_front());
            rsp_log.push_back(cyc);
        end else begin
            chk("rsp_valid", 32'(rd_rsp_valid), 0);
        end
        chk("rsp_data", 32'(rd_rsp_data), 32'(e_rsp));
        idle = (cyc >= free_cyc);
        gw = idle && wr_req_valid && (!rd_req_valid || last_rd);
        gr = idle && rd_req_valid && (!wr_req_valid || !last_rd);
        chk("wr_ready", 32'(wr_req_ready), 32'(gw));
        chk("rd_ready", 32'(rd_req_ready), 32'(gr));
        if (wr_req_valid && wr_req_ready) grants = {grants, "W"};
        if (rd_req_valid && rd_req_ready) grants = {grants, "R"};
        if (gw) begin
            e_wa = wr_req_addr; e_din = wr_req_data;
            ref_mem[wr_req_addr] = wr_req_data;
            wr_cyc = cyc + 1; free_cyc = cyc + 2; last_rd = 1'b0;
            $display("cycle %0d: write accepted addr=%02h data=%04h", cyc, wr_req_addr, wr_req_data);
        end
        if (gr) begin
            e_ra = rd_req_addr;
            rd_cyc = cyc + 1; free_cyc = cyc + 3; last_rd = 1'b1; last_rd_acc = cyc;
            rsp_cyc_q.push_back(cyc + 3);
            rsp_dat_q.push_back(ref_mem[rd_req_addr]);
            $display("cycle %0d: read accepted addr=%02h expect=%04h", cyc, rd_req_addr, ref_mem[rd_req_addr]);
        end
        @(posedge clk); #1;
        cyc++;
        if (gw) void'(wq.pop_front());
        if (gr) void'(rq.pop_front());
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wq.size() != 0 || rq.size() != 0 || rsp_cyc_q.size() != 0 || cyc < free_cyc) && n < 200) begin
            run_cycle();
            n++;
        end
        chk("idle_timeout", 32'(n < 200), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        @(posedge clk); #1; cyc++;
        chk_all_zero("reset");
        chk("reset_wr_ready", 32'(wr_req_ready), 0);
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        rst = 1'b1; preload = 1'b1;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
        rd_req_valid = 1'b0; rd_req_addr = '0;
        grants = "";
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        @(posedge clk); #1; cyc++;
        preload = 1'b0;
        do_reset();

        // Basic write then read of the same address.
        wq.push_back({8'h10, 16'h00A5});
        wait_idle();
        rq.push_back(8'h10);
        wait_idle();
        chk("basic_data", 32'(rd_rsp_data), 32'h00A5);
        chk("basic_latency", 32'(rsp_log[rsp_log.size()-1] - last_rd_acc), 3);

        // Contention straight out of reset: write wins first.
        do_reset();
        grants = "";
        wq.push_back({8'h20, 16'h1234});
        rq.push_back(8'h20);
        wait_idle();
        chk_str("contention_order", grants, "WR");
        chk("contention_data", 32'(rd_rsp_data), 32'h1234);

        // Round-robin with both clients continuously requesting.
        grants = "";
        for (int i = 0; i < 3; i++) begin
            wq.push_back({8'(8'h40 + i), 16'($urandom)});
            rq.push_back(8'(8'h60 + i));
        end
        wait_idle();
        chk_str("round_robin", grants, "WRWRWR");

        // Back-to-back reads across the address extremes.
        wq.push_back({8'h00, 16'h1111});
        wq.push_back({8'hFF, 16'hFFFF});
        wq.push_back({8'h01, 16'h0101});
        wait_idle();
        rsp_log.delete();
        rq.push_back(8'h00); rq.push_back(8'hFF); rq.push_back(8'h01);
        wait_idle();
        chk("b2b_count", 32'(rsp_log.size()), 3);
        if (rsp_log.size() == 3) begin
            chk("b2b_spacing0", 32'(rsp_log[1] - rsp_log[0]), 3);
            chk("b2b_spacing1", 32'(rsp_log[2] - rsp_log[1]), 3);
        end
        chk("b2b_last_data", 32'(rd_rsp_data), 32'h0101);

        // Reset while the controller is in RD.
        rq.push_back(8'h33);
        while (rsp_cyc_q.size() == 0 && cyc < 5000) run_cycle();
        chk("rd_state_mem_read", 32'(mem_read), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) run_cycle();
        rq.push_back(8'h10);
        wait_idle();
        chk("post_reset_read", 32'(rd_rsp_data), 32'h00A5);

        // Idle stability.
        for (int i = 0; i < 20; i++) run_cycle();
        chk("idle_rsp_hold", 32'(rd_rsp_data), 32'h00A5);

        // Randomised traffic over a small address pool plus both extremes.
        for (int i = 0; i < 400; i++) begin
            if (wq.size() < 2 && $urandom_range(0, 2) == 0) begin
                a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                                : 8'(8'h80 + $urandom_range(0, 7));
                wq.push_back({a, 16'($urandom)});
            end
            if (rq.size() < 2 && $urandom_range(0, 2) == 0) begin
                a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                                : 8'(8'h80 + $urandom_range(0, 7));
                rq.push_back(a);
            end
            run_cycle();
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
